hazard_scoreboard: RTL

- Parametrised hazard and stall unit for the 16-bit in-order pipeline, located between fetch and the IF/ID register.
- Keeps a shift-register scoreboard of destination registers for instructions already past decode (EX, MEM, WB, ...).
- Detects RAW hazards for the instruction in ID, and either stalls or relies on forwarding, depending on mode.
- Injects NOPs, drains the pipeline on HALT and raises a sticky halt. Also counts stall cycles for performance reporting.

---
 rtl/hazard_scoreboard.sv | 70 +++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW hazard detection, bubble injection, halt drain and stall counting for an in-order pipeline
module hazard_scoreboard #(
   parameter int INST_W = 16,
   parameter int REG_W = 3,
   parameter int DEPTH = 3,
   parameter int FWD_EN = 0,
   parameter int RF_BYPASS = 1,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(16'h0800),
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [INST_W-1:0] if_inst,
   input  logic              ext_stall,
   input  logic              id_rs_vld,
   input  logic [REG_W-1:0]  id_rs,
   input  logic              id_rt_vld,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              id_wr_vld,
   input  logic [REG_W-1:0]  id_wr,
   input  logic              id_is_load,
   input  logic              id_is_halt,
   output logic [INST_W-1:0] inst_out,
   output logic              stall,
   output logic              halt,
   output logic              busy,
   output logic [CNT_W-1:0]  stall_count
);
   localparam int LAST = DEPTH - 1 - RF_BYPASS;
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
   state_t state;
   logic [DEPTH-1:0] vld;
   logic [DEPTH-1:0][REG_W-1:0] regs;
   logic ld0;
   logic hit, hazard, run;
   // only the EX entry's load flag is ever consulted (load-use), so older stages drop it
   always_comb begin
      hazard = 1'b0;
      hit = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
         hit = vld[e] & ((id_rs_vld & (id_rs == regs[e])) | (id_rt_vld & (id_rt == regs[e])));
         hazard = hazard | ((FWD_EN != 0) ? (e == 0 && hit && ld0) : (e <= LAST && hit));
      end
   end
   assign run = (state == RUN);
   assign stall = hazard & run;
   assign inst_out = (stall | ~run | id_is_halt) ? NOP_INST : if_inst;
   assign busy = |vld;
   assign halt = (state == HALTED);
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         regs <= '0;
         ld0 <= 1'b0;
         state <= RUN;
         stall_count <= '0;
      end else if (!ext_stall) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            vld[i] <= vld[i-1];
            regs[i] <= regs[i-1];
         end
         vld[0] <= id_wr_vld & ~stall & run & ~id_is_halt;
         regs[0] <= id_wr;
         ld0 <= id_is_load;
         if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
         state <= (run && !stall && id_is_halt) ? DRAIN :
                  (state == DRAIN && !busy) ? HALTED : state;
      end
   end
endmodule
